// File: rtl/select_next_hop.sv
// Next-hop selector: scans the neighbor table read-only and picks the lowest-qValue neighbor
// advertising target_sink. Define SNH_BATTERY_FILTER_EN to compile in the battery-floor filter.
`ifndef WORD_WIDTH
`define WORD_WIDTH 16
`endif

module select_next_hop #(
  parameter int unsigned WORD_WIDTH = `WORD_WIDTH,
  parameter int unsigned MAX_SINKS  = 8
) (
  input  logic                  clock,
  input  logic                  rst,
  input  logic                  start,
  input  logic [WORD_WIDTH-1:0] target_sink,
  input  logic [WORD_WIDTH-1:0] exclude_id,
  input  logic [WORD_WIDTH-1:0] min_battery,
  input  logic [WORD_WIDTH-1:0] data_in,
  output logic [WORD_WIDTH-1:0] address,
  output logic [WORD_WIDTH-1:0] best_nID,
  output logic [WORD_WIDTH-1:0] best_qValue,
  output logic [WORD_WIDTH-1:0] best_clusterID,
  output logic                  valid,
  output logic                  done
);

  localparam int unsigned MaxNbrs = 64;
  localparam logic [WORD_WIDTH-1:0] AddrNcnt = WORD_WIDTH'(16'h068A);
  localparam logic [WORD_WIDTH-1:0] AddrNid  = WORD_WIDTH'(16'h0048);
  localparam logic [WORD_WIDTH-1:0] AddrClus = WORD_WIDTH'(16'h00C8);
  localparam logic [WORD_WIDTH-1:0] AddrBatt = WORD_WIDTH'(16'h0148);
  localparam logic [WORD_WIDTH-1:0] AddrQ    = WORD_WIDTH'(16'h01C8);
  localparam logic [WORD_WIDTH-1:0] AddrSink = WORD_WIDTH'(16'h0248);
  localparam logic [WORD_WIDTH-1:0] AddrScnt = WORD_WIDTH'(16'h068E);
  localparam logic [WORD_WIDTH-1:0] MaxNbrsW  = WORD_WIDTH'(MaxNbrs);
  localparam logic [WORD_WIDTH-1:0] MaxSinksW = WORD_WIDTH'(MAX_SINKS);
  localparam logic [3:0]            MaxSinksK = 4'(MAX_SINKS);

  typedef enum logic [3:0] {
    StIdle,
    StRdNcnt,
    StChkN,
    StRdNid,
    StRdScnt,
    StRdSink,
    StRdBatt,
    StRdQ,
    StNext,
    StRdClus,
    StDone
  } state_e;

  state_e                state_q, state_d;
  logic                  cap_q, cap_d;  // 0: issue phase, 1: capture phase of a read
  logic [WORD_WIDTH-1:0] address_q, address_d;
  logic [WORD_WIDTH-1:0] rd_addr;
  logic [6:0]            n_q, n_d;
  logic [6:0]            n_inc;
  logic [6:0]            ncnt_q, ncnt_d;
  logic [3:0]            k_q, k_d;
  logic [3:0]            k_inc;
  logic [3:0]            scnt_q, scnt_d;
  logic [6:0]            best_n_q, best_n_d;
  logic [WORD_WIDTH-1:0] nid_q, nid_d;
  logic [WORD_WIDTH-1:0] best_nid_q, best_nid_d;
  logic [WORD_WIDTH-1:0] best_q_q, best_q_d;
  logic [WORD_WIDTH-1:0] best_clus_q, best_clus_d;
  logic                  valid_q, valid_d;
  logic                  done_q, done_d;
  logic [WORD_WIDTH-1:0] tgt_q, tgt_d;
  logic [WORD_WIDTH-1:0] excl_q, excl_d;

`ifdef SNH_BATTERY_FILTER_EN
  logic [WORD_WIDTH-1:0] minb_q, minb_d;
`else
  logic unused_min_battery;
  assign unused_min_battery = ^min_battery;
`endif

  assign n_inc = n_q + 7'd1;
  assign k_inc = k_q + 4'd1;

  // Address of the word the current read state fetches.
  always_comb begin
    rd_addr = address_q;
    case (state_q)
      StRdNcnt: rd_addr = AddrNcnt;
      StRdNid:  rd_addr = AddrNid + WORD_WIDTH'({n_q, 1'b0});
      StRdScnt: rd_addr = AddrScnt + WORD_WIDTH'({n_q, 1'b0});
      StRdSink: rd_addr = AddrSink + WORD_WIDTH'({n_q, 4'b0000}) + WORD_WIDTH'({k_q, 1'b0});
      StRdBatt: rd_addr = AddrBatt + WORD_WIDTH'({n_q, 1'b0});
      StRdQ:    rd_addr = AddrQ + WORD_WIDTH'({n_q, 1'b0});
      StRdClus: rd_addr = AddrClus + WORD_WIDTH'({best_n_q, 1'b0});
      default:  rd_addr = address_q;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    cap_d       = 1'b0;
    address_d   = address_q;
    n_d         = n_q;
    ncnt_d      = ncnt_q;
    k_d         = k_q;
    scnt_d      = scnt_q;
    best_n_d    = best_n_q;
    nid_d       = nid_q;
    best_nid_d  = best_nid_q;
    best_q_d    = best_q_q;
    best_clus_d = best_clus_q;
    valid_d     = valid_q;
    done_d      = done_q;
    tgt_d       = tgt_q;
    excl_d      = excl_q;
`ifdef SNH_BATTERY_FILTER_EN
    minb_d      = minb_q;
`endif

    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          tgt_d       = target_sink;
          excl_d      = exclude_id;
`ifdef SNH_BATTERY_FILTER_EN
          minb_d      = min_battery;
`endif
          done_d      = 1'b0;
          valid_d     = 1'b0;
          best_q_d    = '1;
          best_nid_d  = '1;
          best_clus_d = '0;
          n_d         = '0;
          address_d   = AddrNcnt;
          state_d     = StRdNcnt;
        end
      end

      StRdNcnt: begin
        if (!cap_q) begin
          address_d = rd_addr;
          cap_d     = 1'b1;
        end else begin
          ncnt_d  = (data_in > MaxNbrsW) ? 7'd64 : data_in[6:0];
          state_d = StChkN;
        end
      end

      StChkN: begin
        if (n_q == ncnt_q) begin
          if (valid_q) begin
            state_d = StRdClus;
          end else begin
            state_d = StDone;
            done_d  = 1'b1;
          end
        end else begin
          state_d = StRdNid;
        end
      end

      StRdNid: begin
        if (!cap_q) begin
          address_d = rd_addr;
          cap_d     = 1'b1;
        end else begin
          nid_d   = data_in;
          state_d = (data_in == excl_q) ? StNext : StRdScnt;
        end
      end

      StRdScnt: begin
        if (!cap_q) begin
          address_d = rd_addr;
          cap_d     = 1'b1;
        end else begin
          scnt_d  = (data_in > MaxSinksW) ? MaxSinksK : data_in[3:0];
          k_d     = '0;
          state_d = (data_in == '0) ? StNext : StRdSink;
        end
      end

      StRdSink: begin
        if (!cap_q) begin
          address_d = rd_addr;
          cap_d     = 1'b1;
        end else if (data_in == tgt_q) begin
`ifdef SNH_BATTERY_FILTER_EN
          state_d = StRdBatt;
`else
          state_d = StRdQ;
`endif
        end else begin
          k_d = k_inc;
          if (k_inc == scnt_q) state_d = StNext;
        end
      end

`ifdef SNH_BATTERY_FILTER_EN
      StRdBatt: begin
        if (!cap_q) begin
          address_d = rd_addr;
          cap_d     = 1'b1;
        end else begin
          state_d = (data_in < minb_q) ? StNext : StRdQ;
        end
      end
`endif

      StRdQ: begin
        if (!cap_q) begin
          address_d = rd_addr;
          cap_d     = 1'b1;
        end else begin
          // Strict compare: earlier index keeps ties, and 16'hFFFF can never win.
          if (data_in < best_q_q) begin
            best_q_d   = data_in;
            best_n_d   = n_q;
            best_nid_d = nid_q;
            valid_d    = 1'b1;
          end
          state_d = StNext;
        end
      end

      // The end-of-table check is folded in here so NEXT costs a single cycle.
      StNext: begin
        n_d = n_inc;
        if (n_inc == ncnt_q) begin
          if (valid_q) begin
            state_d = StRdClus;
          end else begin
            state_d = StDone;
            done_d  = 1'b1;
          end
        end else begin
          state_d = StRdNid;
        end
      end

      StRdClus: begin
        if (!cap_q) begin
          address_d = rd_addr;
          cap_d     = 1'b1;
        end else begin
          best_clus_d = data_in;
          state_d     = StDone;
          done_d      = 1'b1;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      state_q     <= StIdle;
      cap_q       <= 1'b0;
      address_q   <= '0;
      n_q         <= '0;
      ncnt_q      <= '0;
      k_q         <= '0;
      scnt_q      <= '0;
      best_n_q    <= '0;
      nid_q       <= '0;
      best_nid_q  <= '1;
      best_q_q    <= '1;
      best_clus_q <= '0;
      valid_q     <= 1'b0;
      done_q      <= 1'b0;
      tgt_q       <= '0;
      excl_q      <= '0;
`ifdef SNH_BATTERY_FILTER_EN
      minb_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      cap_q       <= cap_d;
      address_q   <= address_d;
      n_q         <= n_d;
      ncnt_q      <= ncnt_d;
      k_q         <= k_d;
      scnt_q      <= scnt_d;
      best_n_q    <= best_n_d;
      nid_q       <= nid_d;
      best_nid_q  <= best_nid_d;
      best_q_q    <= best_q_d;
      best_clus_q <= best_clus_d;
      valid_q     <= valid_d;
      done_q      <= done_d;
      tgt_q       <= tgt_d;
      excl_q      <= excl_d;
`ifdef SNH_BATTERY_FILTER_EN
      minb_q      <= minb_d;
`endif
    end
  end

  assign address        = address_q;
  assign best_nID       = best_nid_q;
  assign best_qValue    = best_q_q;
  assign best_clusterID = best_clus_q;
  assign valid          = valid_q;
  assign done           = done_q;

endmodule

// File: tb/tb_select_next_hop.sv
// Bench for select_next_hop: behavioural memory, table-driven scans, scoreboard of expected
// results pushed at start and popped at done.
module tb_select_next_hop;

  typedef struct packed {
    logic        v;
    logic [15:0] nid;
    logic [15:0] q;
    logic [15:0] clus;
  } res_t;

  logic        clock = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] target_sink;
  logic [15:0] exclude_id;
  logic [15:0] min_battery;
  logic [15:0] data_in;
  logic [15:0] address;
  logic [15:0] best_nID;
  logic [15:0] best_qValue;
  logic [15:0] best_clusterID;
  logic        valid;
  logic        done;

  logic [15:0] mem [0:1023];
  res_t        exp_q[$];
  int          n_vec = 0;
  int          n_bad = 0;
  logic        mon_en = 1'b0;
  logic [15:0] sink_addr_max = 16'h0000;

  select_next_hop dut (
    .clock          (clock),
    .rst            (rst),
    .start          (start),
    .target_sink    (target_sink),
    .exclude_id     (exclude_id),
    .min_battery    (min_battery),
    .data_in        (data_in),
    .address        (address),
    .best_nID       (best_nID),
    .best_qValue    (best_qValue),
    .best_clusterID (best_clusterID),
    .valid          (valid),
    .done           (done)
  );

  always #5 clock = ~clock;

  assign data_in = mem[address[10:1]];

  always @(posedge clock) begin
    if (mon_en && address >= 16'h0248 && address < 16'h0648 && address > sink_addr_max)
      sink_addr_max <= address;
  end

  function automatic logic [15:0] rd(input int a);
    return mem[a[10:1]];
  endfunction

  task automatic wr(input int a, input logic [15:0] d);
    mem[a[10:1]] = d;
  endtask

  function automatic string fmt(input res_t r);
    return $sformatf("v=%0b nid=%h q=%h clus=%h", r.v, r.nid, r.q, r.clus);
  endfunction

  // Reference: walk the table the straightforward way.
  function automatic res_t model(input logic [15:0] tgt, input logic [15:0] excl,
                                 input logic [15:0] minb);
    res_t r;
    int cnt, sc;
    bit hit;
    logic [15:0] id, q;
    r = '{v: 1'b0, nid: 16'hFFFF, q: 16'hFFFF, clus: 16'h0000};
    cnt = int'(rd('h68A));
    if (cnt > 64) cnt = 64;
    for (int n = 0; n < cnt; n++) begin
      id = rd('h48 + 2 * n);
      if (id == excl) continue;
      sc = int'(rd('h68E + 2 * n));
      if (sc > 8) sc = 8;
      hit = 1'b0;
      for (int k = 0; k < sc; k++) if (rd('h248 + 16 * n + 2 * k) == tgt) hit = 1'b1;
      if (!hit) continue;
`ifdef SNH_BATTERY_FILTER_EN
      if (rd('h148 + 2 * n) < minb) continue;
`endif
      q = rd('h1C8 + 2 * n);
      if (q < r.q) begin
        r.q = q;
        r.nid = id;
        r.v = 1'b1;
        r.clus = rd('hC8 + 2 * n);
      end
    end
    if (minb === 16'hxxxx) r.v = 1'bx;
    return r;
  endfunction

  task automatic clear_mem();
    for (int i = 0; i < 1024; i++) mem[i] = 16'h0000;
  endtask

  // Sink slots hold filler IDs with the advertised sink in the last listed slot.
  task automatic set_nbr(input int n, input logic [15:0] id, input logic [15:0] clus,
                         input logic [15:0] batt, input logic [15:0] q, input int scnt,
                         input logic [15:0] sink);
    wr('h48 + 2 * n, id);
    wr('hC8 + 2 * n, clus);
    wr('h148 + 2 * n, batt);
    wr('h1C8 + 2 * n, q);
    wr('h68E + 2 * n, 16'(scnt));
    for (int k = 0; k < scnt && k < 8; k++)
      wr('h248 + 16 * n + 2 * k, (k == scnt - 1) ? sink : 16'(100 + k));
  endtask

  task automatic load_basic();
    clear_mem();
    wr('h68A, 16'd3);
    set_nbr(0, 16'd5, 16'h0100, 16'd60, 16'd30, 3, 16'd2);
    set_nbr(1, 16'd7, 16'h0101, 16'd40, 16'd10, 2, 16'd2);
    set_nbr(2, 16'd9, 16'h0102, 16'd70, 16'd20, 1, 16'd2);
  endtask

  task automatic run_scan(input logic [15:0] tgt, input logic [15:0] excl,
                          input logic [15:0] minb, output res_t got, output int cyc);
    @(negedge clock);
    target_sink = tgt;
    exclude_id  = excl;
    min_battery = minb;
    start       = 1'b1;
    exp_q.push_back(model(tgt, excl, minb));
    @(negedge clock);
    start = 1'b0;
    cyc   = 1;
    while (done !== 1'b1 && cyc < 3000) begin
      @(negedge clock);
      cyc++;
    end
    got = '{v: valid, nid: best_nID, q: best_qValue, clus: best_clusterID};
  endtask

  task automatic test_reset();
    res_t got;
    rst = 1'b1;
    repeat (3) @(negedge clock);
    rst = 1'b0;
    got = '{v: valid, nid: best_nID, q: best_qValue, clus: best_clusterID};
    n_vec++;
    if (got !== '{v: 1'b0, nid: 16'hFFFF, q: 16'hFFFF, clus: 16'h0000}) begin
      n_bad++;
      $display("FAIL reset_outputs: got %s, need v=0 nid=ffff q=ffff clus=0000", fmt(got));
    end
    n_vec++;
    if (address !== 16'h0000 || done !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_addr_done: got addr=%h done=%b, need addr=0000 done=0", address, done);
    end
  endtask

  task automatic test_empty();
    res_t got, exp;
    int cyc;
    clear_mem();
    run_scan(16'd2, 16'hFFFE, 16'd0, got, cyc);
    exp = exp_q.pop_front();
    n_vec++;
    if (got !== exp || done !== 1'b1) begin
      n_bad++;
      $display("FAIL empty_result: got %s done=%b, need %s done=1", fmt(got), done, fmt(exp));
    end
    n_vec++;
    if (cyc != 4) begin
      n_bad++;
      $display("FAIL empty_latency: got %0d cycles, need 4", cyc);
    end
  endtask

  task automatic test_basic();
    res_t got, exp;
    int cyc;
    load_basic();
    run_scan(16'd2, 16'hFFFE, 16'd0, got, cyc);
    exp = exp_q.pop_front();
    n_vec++;
    if (got !== exp || done !== 1'b1) begin
      n_bad++;
      $display("FAIL basic_scoreboard: got %s done=%b, need %s", fmt(got), done, fmt(exp));
    end
    n_vec++;
    if (got !== '{v: 1'b1, nid: 16'd7, q: 16'd10, clus: 16'h0101}) begin
      n_bad++;
      $display("FAIL basic_fixed: got %s, need v=1 nid=0007 q=000a clus=0101", fmt(got));
    end
  endtask

  task automatic test_exclude();
    res_t got, exp;
    int cyc;
    load_basic();
    run_scan(16'd2, 16'd7, 16'd0, got, cyc);
    exp = exp_q.pop_front();
    n_vec++;
    if (got !== exp || done !== 1'b1) begin
      n_bad++;
      $display("FAIL exclude_scoreboard: got %s, need %s", fmt(got), fmt(exp));
    end
    n_vec++;
    if (got.nid !== 16'd9 || got.q !== 16'd20) begin
      n_bad++;
      $display("FAIL exclude_fixed: got nid=%h q=%h, need nid=0009 q=0014", got.nid, got.q);
    end
  endtask

  task automatic test_missing_sink();
    res_t got, exp;
    int cyc;
    load_basic();
    set_nbr(1, 16'd7, 16'h0101, 16'd40, 16'd10, 2, 16'd99);
    run_scan(16'd2, 16'hFFFE, 16'd0, got, cyc);
    exp = exp_q.pop_front();
    n_vec++;
    if (got !== exp || got.nid !== 16'd9 || got.clus !== 16'h0102) begin
      n_bad++;
      $display("FAIL missing_sink: got %s, need %s (nid 0009)", fmt(got), fmt(exp));
    end
  endtask

  task automatic test_tie();
    res_t got, exp;
    int cyc;
    load_basic();
    set_nbr(0, 16'd5, 16'h0100, 16'd60, 16'd10, 3, 16'd2);
    set_nbr(1, 16'd7, 16'h0101, 16'd40, 16'd30, 2, 16'd2);
    set_nbr(2, 16'd9, 16'h0102, 16'd70, 16'd10, 1, 16'd2);
    run_scan(16'd2, 16'hFFFE, 16'd0, got, cyc);
    exp = exp_q.pop_front();
    n_vec++;
    if (got !== exp || got.nid !== 16'd5 || got.clus !== 16'h0100) begin
      n_bad++;
      $display("FAIL tie_lowest_index: got %s, need %s (nid 0005)", fmt(got), fmt(exp));
    end
  endtask

  task automatic test_qvalue_max();
    res_t got, exp;
    int cyc;
    clear_mem();
    wr('h68A, 16'd1);
    set_nbr(0, 16'd5, 16'h0100, 16'd60, 16'hFFFF, 1, 16'd2);
    run_scan(16'd2, 16'hFFFE, 16'd0, got, cyc);
    exp = exp_q.pop_front();
    n_vec++;
    if (got !== exp || got.v !== 1'b0 || got.nid !== 16'hFFFF) begin
      n_bad++;
      $display("FAIL qvalue_ffff: got %s, need %s", fmt(got), fmt(exp));
    end
  endtask

  task automatic test_sink_clamp();
    res_t got, exp;
    int cyc;
    clear_mem();
    wr('h68A, 16'd1);
    set_nbr(0, 16'd5, 16'h0100, 16'd60, 16'd10, 12, 16'd2);
    // Row 1 holds the target, so reading past slot 7 of row 0 would falsely match.
    for (int k = 0; k < 4; k++) wr('h258 + 2 * k, 16'd2);
    sink_addr_max = 16'h0000;
    mon_en = 1'b1;
    run_scan(16'd2, 16'hFFFE, 16'd0, got, cyc);
    mon_en = 1'b0;
    exp = exp_q.pop_front();
    n_vec++;
    if (got !== exp || got.v !== 1'b0) begin
      n_bad++;
      $display("FAIL clamp_result: got %s, need %s", fmt(got), fmt(exp));
    end
    n_vec++;
    if (sink_addr_max !== 16'h0256) begin
      n_bad++;
      $display("FAIL clamp_max_addr: got %h, need 0256", sink_addr_max);
    end
  endtask

  task automatic test_battery();
    res_t got, exp;
    int cyc;
    logic [15:0] want_nid;
`ifdef SNH_BATTERY_FILTER_EN
    want_nid = 16'd9;
`else
    want_nid = 16'd7;
`endif
    load_basic();
    run_scan(16'd2, 16'hFFFE, 16'd50, got, cyc);
    exp = exp_q.pop_front();
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL battery_scoreboard: got %s, need %s", fmt(got), fmt(exp));
    end
    n_vec++;
    if (got.nid !== want_nid) begin
      n_bad++;
      $display("FAIL battery_fixed: got nid=%h, need %h", got.nid, want_nid);
    end
  endtask

  task automatic test_reset_mid();
    res_t got, exp;
    int cyc, w;
    load_basic();
    @(negedge clock);
    target_sink = 16'd2;
    exclude_id  = 16'hFFFE;
    min_battery = 16'd0;
    start       = 1'b1;
    @(negedge clock);
    start = 1'b0;
    w = 0;
    while (!(address >= 16'h0258 && address <= 16'h025A) && w < 200) begin
      @(negedge clock);
      w++;
    end
    n_vec++;
    if (w >= 200) begin
      n_bad++;
      $display("FAIL midreset_reach_sink: address stuck at %h, need 0258..025a", address);
    end
    rst = 1'b1;
    @(negedge clock);
    got = '{v: valid, nid: best_nID, q: best_qValue, clus: best_clusterID};
    rst = 1'b0;
    n_vec++;
    if (got !== '{v: 1'b0, nid: 16'hFFFF, q: 16'hFFFF, clus: 16'h0000} ||
        address !== 16'h0000 || done !== 1'b0) begin
      n_bad++;
      $display("FAIL midreset_values: got %s addr=%h done=%b, need v=0 nid=ffff q=ffff clus=0000 addr=0000 done=0",
               fmt(got), address, done);
    end
    run_scan(16'd2, 16'hFFFE, 16'd0, got, cyc);
    exp = exp_q.pop_front();
    n_vec++;
    if (got !== exp || done !== 1'b1) begin
      n_bad++;
      $display("FAIL midreset_rescan: got %s done=%b, need %s", fmt(got), done, fmt(exp));
    end
  endtask

  task automatic test_back_to_back();
    res_t got, exp;
    int cyc;
    load_basic();
    @(negedge clock);
    target_sink = 16'd2;
    exclude_id  = 16'hFFFE;
    min_battery = 16'd0;
    start       = 1'b1;
    exp_q.push_back(model(16'd2, 16'hFFFE, 16'd0));
    @(negedge clock);
    start = 1'b0;
    repeat (5) @(negedge clock);
    // Mid-scan request with a different target must be ignored.
    target_sink = 16'd77;
    start       = 1'b1;
    @(negedge clock);
    start = 1'b0;
    cyc   = 0;
    while (done !== 1'b1 && cyc < 3000) begin
      @(negedge clock);
      cyc++;
    end
    got = '{v: valid, nid: best_nID, q: best_qValue, clus: best_clusterID};
    exp = exp_q.pop_front();
    n_vec++;
    if (got !== exp || done !== 1'b1) begin
      n_bad++;
      $display("FAIL ignore_midscan_start: got %s done=%b, need %s", fmt(got), done, fmt(exp));
    end
    run_scan(16'd2, 16'd7, 16'd0, got, cyc);
    exp = exp_q.pop_front();
    n_vec++;
    if (got !== exp || done !== 1'b1 || got.nid !== 16'd9) begin
      n_bad++;
      $display("FAIL restart_from_done: got %s done=%b, need %s", fmt(got), done, fmt(exp));
    end
  endtask

  initial begin
    rst         = 1'b1;
    start       = 1'b0;
    target_sink = 16'h0000;
    exclude_id  = 16'h0000;
    min_battery = 16'h0000;
    clear_mem();
    test_reset();
    test_empty();
    test_basic();
    test_exclude();
    test_missing_sink();
    test_tie();
    test_qvalue_max();
    test_sink_clamp();
    test_battery();
    test_reset_mid();
    test_back_to_back();
    n_vec++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drained: got %0d pending, need 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
